// File: rtl/fib_seq_gen.sv
// -----------------------------------------------------------------------------
// fib_seq_gen
//   Computes the n-th term of a programmable second-order recurrence, one term
//   per clock, starting from user seeds x0/x1:
//     mode 0 : x_{k+2} = x_{k+1} + x_k       (Fibonacci)
//     mode 1 : x_{k+2} = 2*x_{k+1} + x_k     (Pell)
//     mode 2 : x_{k+2} = x_{k+1} + 2*x_k     (Jacobsthal)
//     mode 3 : same as mode 0
//   Every term x0..xn is pushed into a circular history that can be read back
//   (address 0 = newest term, 1-cycle registered read, read-before-write).
//
// Configuration macro:
//   FIB_SAT_EN  - when defined, terms that exceed 2^WIDTH-1 clamp to all-ones
//                 and set the sticky o_ovf flag (cleared on accept/reset).
//                 When undefined, arithmetic wraps and o_ovf is tied to 0.
//
// Control handshake:
//   A request is accepted on a rising edge where i_stb=1 and o_busy=0; seeds,
//   i_n and i_mode are latched at that edge. o_busy stays high while
//   iterations remain and strobes during that time are dropped. o_done pulses
//   for one cycle when o_fib holds the final term; a new request may be
//   accepted in that same cycle.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_stb               start request
//   i_n                 index of the requested term
//   i_seed0, i_seed1    x0, x1
//   i_mode              recurrence select
//   i_rd_addr           history index (0 = most recent)
//   o_busy              iterations remaining
//   o_done              one-cycle completion pulse
//   o_fib               current term x_k
//   o_rd_data           registered history read data
//   o_hist_count        number of valid history entries
//   o_ovf               sticky overflow flag
// -----------------------------------------------------------------------------
module fib_seq_gen #(
  parameter int WIDTH      = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int HIST_DEPTH = 8,
  localparam int AW        = $clog2(HIST_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_stb,
  input  logic [CNT_WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0]     i_seed0,
  input  logic [WIDTH-1:0]     i_seed1,
  input  logic [1:0]           i_mode,
  input  logic [AW-1:0]        i_rd_addr,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [WIDTH-1:0]     o_fib,
  output logic [WIDTH-1:0]     o_rd_data,
  output logic [AW:0]          o_hist_count,
  output logic                 o_ovf
);

  logic [WIDTH-1:0]     cur_q, cur_d;
  logic [WIDTH-1:0]     nxt_q, nxt_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [1:0]           mode_q, mode_d;
  logic [AW-1:0]        wp_q, wp_d;      // slot the next push writes
  logic [AW:0]          cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     rd_q;
  logic [WIDTH-1:0]     hist_q [HIST_DEPTH];

  logic             busy;
  logic             accept;
  logic             push;
  logic [WIDTH-1:0] push_val;
  logic [AW-1:0]    push_idx;

  // Recurrence evaluated two bits wider so a carry out is never lost.
  logic [WIDTH+1:0] a_x, b_x, f_x;
  logic [WIDTH-1:0] f_red;
  logic             f_ovf;

  assign busy   = (rem_q != '0);
  assign accept = i_stb && !busy;

  always_comb begin
    a_x = {2'b00, cur_q};
    b_x = {2'b00, nxt_q};
    case (mode_q)
      2'd1:    f_x = (b_x << 1) + a_x;
      2'd2:    f_x = b_x + (a_x << 1);
      default: f_x = b_x + a_x;
    endcase
`ifdef FIB_SAT_EN
    f_ovf = |f_x[WIDTH+1:WIDTH];
    f_red = f_ovf ? '1 : f_x[WIDTH-1:0];
`else
    f_ovf = 1'b0;
    f_red = f_x[WIDTH-1:0];
`endif
  end

  always_comb begin
    cur_d    = cur_q;
    nxt_d    = nxt_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    wp_d     = wp_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    push     = 1'b0;
    push_val = nxt_q;
    push_idx = wp_q;
    if (accept) begin
      // History restarts with x0 in slot 0; older slots become invalid by count.
      cur_d    = i_seed0;
      nxt_d    = i_seed1;
      rem_d    = i_n;
      mode_d   = i_mode;
      wp_d     = AW'(1);
      cnt_d    = (AW+1)'(1);
      done_d   = (i_n == '0);
      push     = 1'b1;
      push_val = i_seed0;
      push_idx = '0;
    end else if (busy) begin
      cur_d  = nxt_q;
      nxt_d  = f_red;
      rem_d  = rem_q - CNT_WIDTH'(1);
      wp_d   = wp_q + AW'(1);
      cnt_d  = (cnt_q == (AW+1)'(HIST_DEPTH)) ? cnt_q : cnt_q + (AW+1)'(1);
      done_d = (rem_q == CNT_WIDTH'(1));
      push   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cur_q  <= '0;
      nxt_q  <= '0;
      rem_q  <= '0;
      mode_q <= '0;
      wp_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      rd_q   <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      cur_q  <= cur_d;
      nxt_q  <= nxt_d;
      rem_q  <= rem_d;
      mode_q <= mode_d;
      wp_q   <= wp_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      // Read uses the pre-edge pointer/count, so a concurrent push is not seen.
      if ({1'b0, i_rd_addr} < cnt_q) rd_q <= hist_q[wp_q - AW'(1) - i_rd_addr];
      else                           rd_q <= '0;
      if (push) hist_q[push_idx] <= push_val;
    end
  end

`ifdef FIB_SAT_EN
  logic ovf_q;
  always_ff @(posedge i_clk) begin
    if (i_reset)             ovf_q <= 1'b0;
    else if (accept)         ovf_q <= 1'b0;
    else if (busy && f_ovf)  ovf_q <= 1'b1;
  end
  assign o_ovf = ovf_q;
`else
  assign o_ovf = 1'b0;
`endif

  assign o_busy       = busy;
  assign o_done       = done_q;
  assign o_fib        = cur_q;
  assign o_rd_data    = rd_q;
  assign o_hist_count = cnt_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
module tb_fib_seq_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- 32-bit DUT ----------------
  logic        stb = 1'b0;
  logic [15:0] n_in = '0;
  logic [31:0] s0 = '0, s1 = '0;
  logic [1:0]  mode = '0;
  logic [2:0]  rd_addr = '0;
  logic        busy, done, ovf;
  logic [31:0] fib, rd_data;
  logic [3:0]  hcnt;

  fib_seq_gen #(.WIDTH(32), .CNT_WIDTH(16), .HIST_DEPTH(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_n(n_in),
    .i_seed0(s0), .i_seed1(s1), .i_mode(mode), .i_rd_addr(rd_addr),
    .o_busy(busy), .o_done(done), .o_fib(fib), .o_rd_data(rd_data),
    .o_hist_count(hcnt), .o_ovf(ovf)
  );

  // ---------------- 8-bit DUT (overflow behaviour) ----------------
  logic        stb8 = 1'b0;
  logic [15:0] n8 = '0;
  logic [7:0]  s08 = '0, s18 = '0;
  logic [1:0]  mode8 = '0;
  logic [2:0]  addr8 = '0;
  logic        busy8, done8, ovf8;
  logic [7:0]  fib8, rd8;
  logic [3:0]  hcnt8;

  fib_seq_gen #(.WIDTH(8), .CNT_WIDTH(16), .HIST_DEPTH(8)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_stb(stb8), .i_n(n8),
    .i_seed0(s08), .i_seed1(s18), .i_mode(mode8), .i_rd_addr(addr8),
    .o_busy(busy8), .o_done(done8), .o_fib(fib8), .o_rd_data(rd8),
    .o_hist_count(hcnt8), .o_ovf(ovf8)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  mode;
    logic [15:0] n;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] exp_fib;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs [8];

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Returns at the negedge following the accept edge.
  task automatic start(input logic [1:0] m, input logic [15:0] n,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    stb = 1'b1; mode = m; n_in = n; s0 = a; s1 = b;
    @(negedge clk);
    stb = 1'b0;
  endtask

  // Waits (bounded) for o_done; counts cycles from accept and busy cycles.
  task automatic run(output int lat, output int busy_cyc, output logic seen);
    lat = 0; busy_cyc = 0; seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (busy) busy_cyc++;
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  int   lat, bcyc, extra, done_cnt;
  logic seen;

  initial begin
    vecs[0] = '{2'd0, 16'd10, 32'd0, 32'd1, 32'd55, 4'd8};
    vecs[1] = '{2'd1, 16'd6,  32'd0, 32'd1, 32'd70, 4'd7};
    vecs[2] = '{2'd2, 16'd5,  32'd0, 32'd1, 32'd11, 4'd6};
    vecs[3] = '{2'd3, 16'd10, 32'd0, 32'd1, 32'd55, 4'd8};
    vecs[4] = '{2'd0, 16'd0,  32'd7, 32'd9, 32'd7,  4'd1};
    vecs[5] = '{2'd0, 16'd2,  32'd0, 32'd1, 32'd1,  4'd3};
    vecs[6] = '{2'd1, 16'd3,  32'd3, 32'd4, 32'd26, 4'd4};
    vecs[7] = '{2'd2, 16'd4,  32'd2, 32'd5, 32'd37, 4'd5};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_fib",  fib, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_rd",   rd_data, 0);
    chk("rst_cnt",  {28'd0, hcnt}, 0);
    chk("rst_ovf",  {31'd0, ovf}, 0);
    rst = 1'b0;

    // table-driven runs
    for (int v = 0; v < 8; v++) begin
      start(vecs[v].mode, vecs[v].n, vecs[v].s0, vecs[v].s1);
      chk($sformatf("v%0d_x0", v), fib, vecs[v].s0);
      run(lat, bcyc, seen);
      chk($sformatf("v%0d_done_seen", v), {31'd0, seen}, 1);
      chk($sformatf("v%0d_latency", v), lat, {16'd0, vecs[v].n});
      chk($sformatf("v%0d_busy_cycles", v), bcyc, {16'd0, vecs[v].n});
      chk($sformatf("v%0d_fib", v), fib, vecs[v].exp_fib);
      chk($sformatf("v%0d_hist_count", v), {28'd0, hcnt}, {28'd0, vecs[v].exp_cnt});
      chk($sformatf("v%0d_ovf", v), {31'd0, ovf}, 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", v), {31'd0, done}, 0);
    end

    // strobe while busy is ignored; then history readback
    start(2'd0, 16'd10, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    stb = 1'b1; n_in = 16'd2; mode = 2'd1; s0 = 32'd5; s1 = 32'd5;
    @(negedge clk);
    stb = 1'b0;
    run(lat, bcyc, seen);
    chk("ign_done_seen", {31'd0, seen}, 1);
    chk("ign_latency", lat + 4, 10);
    chk("ign_fib", fib, 55);
    rd_addr = 3'd0;
    @(negedge clk);
    chk("rd_addr0", rd_data, 55);
    rd_addr = 3'd7;
    chk("rd_latency_hold", rd_data, 55);
    @(negedge clk);
    chk("rd_addr7", rd_data, 2);

    // short run: partial history, out-of-range address reads 0
    start(2'd0, 16'd2, 32'd4, 32'd6);
    run(lat, bcyc, seen);
    chk("n2_fib", fib, 10);
    chk("n2_count", {28'd0, hcnt}, 3);
    rd_addr = 3'd2;
    @(negedge clk);
    chk("n2_addr2", rd_data, 4);
    rd_addr = 3'd3;
    @(negedge clk);
    chk("n2_addr3", rd_data, 0);

    // reset mid-run
    start(2'd0, 16'd10, 32'd0, 32'd1);
    repeat (4) @(negedge clk);
    chk("mid_x4", fib, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_fib",  fib, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    chk("mid_rst_rd",   rd_data, 0);
    chk("mid_rst_cnt",  {28'd0, hcnt}, 0);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("mid_no_done", done_cnt, 0);
    start(2'd1, 16'd6, 32'd0, 32'd1);
    run(lat, bcyc, seen);
    chk("post_rst_fib", fib, 70);
    chk("post_rst_latency", lat, 6);

    // 8-bit overflow behaviour
    @(negedge clk);
    stb8 = 1'b1; n8 = 16'd14; s08 = 8'd0; s18 = 8'd1; mode8 = 2'd0;
    @(negedge clk);
    stb8 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (done8) seen = 1'b1;
      else @(negedge clk);
    end
    chk("w8_done_seen", {31'd0, seen}, 1);
`ifdef FIB_SAT_EN
    chk("w8_fib", {24'd0, fib8}, 255);
    chk("w8_ovf", {31'd0, ovf8}, 1);
`else
    chk("w8_fib", {24'd0, fib8}, 121);
    chk("w8_ovf", {31'd0, ovf8}, 0);
`endif
    stb8 = 1'b1; n8 = 16'd0; s08 = 8'd1; s18 = 8'd1;
    @(negedge clk);
    stb8 = 1'b0;
    chk("w8_reaccept_done", {31'd0, done8}, 1);
    chk("w8_reaccept_fib", {24'd0, fib8}, 1);
    chk("w8_ovf_cleared", {31'd0, ovf8}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
